// File: rtl/mem_access_unit.sv
// Memory-stage data-bus master.
// Turns one M-stage load/store into a single req/addr_ok/data_ok bus
// transaction, builds store byte strobes and lane-shifted write data, captures
// the returned word and hands it with its byte offset and extension type to the
// load-extension stage.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   M_Valid, M_Flush             M-stage valid / cancel of the current M op
//   M_Addr, M_StoreData          effective address, store source (rt)
//   M_AccessType                 one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,sb,sh,sw,swl,swr}
//   M_Stall                      hold M and earlier stages (combinational)
//   M_AdEL, M_AdES               load/store address error (combinational)
//   data_*                       SRAM-like data-bus master side
//   W_Valid                      one-cycle completion pulse
//   W_RawMemData, W_Offset, W_ExtType  result handed to the extension stage
module mem_access_unit #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              M_Valid,
   input  logic              M_Flush,
   input  logic [ADDR_W-1:0] M_Addr,
   input  logic [DATA_W-1:0] M_StoreData,
   input  logic [11:0]       M_AccessType,
   output logic              M_Stall,
   output logic              M_AdEL,
   output logic              M_AdES,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata,
   output logic              W_Valid,
   output logic [DATA_W-1:0] W_RawMemData,
   output logic [1:0]        W_Offset,
   output logic [8:0]        W_ExtType
);

   localparam int unsigned EXT_W = 9;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [1:0] state;
   logic [1:0] stateNext;

   logic isLb, isLbu, isLh, isLhu, isLw, isLwl, isLwr;
   logic isSb, isSh, isSw, isSwl, isSwr;
   logic [1:0] off;
   logic loadAdE, storeAdE, start, isStore, lineAligned;
   logic cancel;
   logic [1:0] offQ;
   logic [EXT_W-1:0] extQ;

   logic [1:0]        sizeC;
   logic [ADDR_W-1:0] addrC;
   logic [3:0]        wstrbC;
   logic [DATA_W-1:0] wdataC;

   // Access-type decode
   assign {isLb, isLbu, isLh, isLhu, isLw, isLwl, isLwr,
           isSb, isSh, isSw, isSwl, isSwr} = M_AccessType;
   assign off         = M_Addr[1:0];
   assign isStore     = isSb | isSh | isSw | isSwl | isSwr;
   assign lineAligned = isLwl | isLwr | isSwl | isSwr;

   // Misalignment detection; unaligned-word ops (lwl/lwr/swl/swr) never fault
   assign loadAdE  = ((isLh | isLhu) & off[0]) | (isLw & (|off));
   assign storeAdE = (isSh & off[0]) | (isSw & (|off));
   assign M_AdEL   = M_Valid & loadAdE;
   assign M_AdES   = M_Valid & storeAdE;

   assign start = (state == IDLE) & M_Valid & (|M_AccessType) & ~M_Flush
                  & ~loadAdE & ~storeAdE;

   // Stall drops in the data_ok cycle so the pipeline advances with the result
   assign M_Stall = start | (state == REQ) | ((state == WAIT) & ~data_data_ok);

   // Bus size and address
   always_comb begin
      sizeC = 2'd2;
      addrC = M_Addr;
      if (isLb | isLbu | isSb)      sizeC = 2'd0;
      else if (isLh | isLhu | isSh) sizeC = 2'd1;
      if (lineAligned) addrC = {M_Addr[ADDR_W-1:2], 2'b00};
   end

   // Store byte strobes and lane-shifted write data
   always_comb begin
      wstrbC = 4'b0000;
      wdataC = '0;
      if (isSb) begin
         wstrbC = 4'b0001 << off;
         wdataC = {4{M_StoreData[7:0]}};
      end else if (isSh) begin
         wstrbC = 4'b0011 << off;
         wdataC = {2{M_StoreData[15:0]}};
      end else if (isSw) begin
         wstrbC = 4'b1111;
         wdataC = M_StoreData;
      end else if (isSwl) begin
         wstrbC = 4'b1111 >> (2'd3 - off);
         wdataC = M_StoreData >> {(2'd3 - off), 3'b000};
      end else if (isSwr) begin
         wstrbC = 4'b1111 << off;
         wdataC = M_StoreData << {off, 3'b000};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= stateNext;
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start)        stateNext = REQ;
         REQ:     if (data_addr_ok) stateNext = WAIT;
         WAIT:    if (data_data_ok) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Bus fields, cancel tracking and write-back capture
   always_ff @(posedge clk) begin
      if (!resetn) begin
         data_req     <= 1'b0;
         data_wr      <= 1'b0;
         data_size    <= 2'd0;
         data_addr    <= '0;
         data_wstrb   <= 4'b0000;
         data_wdata   <= '0;
         offQ         <= 2'd0;
         extQ         <= '0;
         cancel       <= 1'b0;
         W_Valid      <= 1'b0;
         W_RawMemData <= '0;
         W_Offset     <= 2'd0;
         W_ExtType    <= '0;
      end else begin
         W_Valid <= 1'b0;
         if (start) begin
            data_req   <= 1'b1;
            data_wr    <= isStore;
            data_size  <= sizeC;
            data_addr  <= addrC;
            data_wstrb <= wstrbC;
            data_wdata <= wdataC;
            offQ       <= off;
            extQ       <= {M_AccessType[11:5], M_AccessType[1:0]};
         end else if ((state == REQ) && data_addr_ok) begin
            data_req <= 1'b0;
         end
         if ((state != IDLE) && M_Flush) cancel <= 1'b1;
         // A flush in the data_ok cycle itself also discards the result
         if ((state == WAIT) && data_data_ok) begin
            cancel <= 1'b0;
            if (!(cancel | M_Flush)) begin
               W_Valid   <= 1'b1;
               W_Offset  <= offQ;
               W_ExtType <= extQ;
               if (!data_wr) W_RawMemData <= data_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single transactions plus
// hand-written timing, flush and mid-transaction reset sequences.
module tb_mem_access_unit;

   typedef struct {
      logic [11:0] acc;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] rdata;
      logic [1:0]  size;
      logic [31:0] bAddr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        wr;
      logic        adel;
      logic        ades;
      logic [8:0]  ext;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        M_Valid, M_Flush;
   logic [31:0] M_Addr, M_StoreData;
   logic [11:0] M_AccessType;
   logic        M_Stall, M_AdEL, M_AdES;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        W_Valid;
   logic [31:0] W_RawMemData;
   logic [1:0]  W_Offset;
   logic [8:0]  W_ExtType;

   int checks = 0;
   int errors = 0;
   logic [31:0] expRaw;
   logic [1:0]  expOff;
   logic [8:0]  expExt;
   vec_t vecs[16];
   vec_t v;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .M_Valid(M_Valid), .M_Flush(M_Flush), .M_Addr(M_Addr),
      .M_StoreData(M_StoreData), .M_AccessType(M_AccessType),
      .M_Stall(M_Stall), .M_AdEL(M_AdEL), .M_AdES(M_AdES),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .W_Valid(W_Valid), .W_RawMemData(W_RawMemData),
      .W_Offset(W_Offset), .W_ExtType(W_ExtType)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic present(input logic [11:0] acc, input logic [31:0] addr, input logic [31:0] sd);
      M_Valid = 1'b1; M_Flush = 1'b0;
      M_AccessType = acc; M_Addr = addr; M_StoreData = sd;
   endtask

   task automatic dropM();
      M_Valid = 1'b0; M_AccessType = 12'h000; M_Flush = 1'b0;
   endtask

   task automatic chkWb(input string tag, input logic expValid);
      chk($sformatf("%s_wvalid", tag), 32'(W_Valid), 32'(expValid));
      chk($sformatf("%s_wraw", tag), W_RawMemData, expRaw);
      chk($sformatf("%s_woff", tag), 32'(W_Offset), 32'(expOff));
      chk($sformatf("%s_wext", tag), 32'(W_ExtType), 32'(expExt));
   endtask

   // One complete transaction: addr_ok in the first REQ cycle, data_ok next
   task automatic runVec(input vec_t tv, input string tag);
      @(negedge clk);
      present(tv.acc, tv.addr, tv.sd);
      #1;
      chk($sformatf("%s_adel", tag), 32'(M_AdEL), 32'(tv.adel));
      chk($sformatf("%s_ades", tag), 32'(M_AdES), 32'(tv.ades));
      if (tv.adel || tv.ades) begin
         chk($sformatf("%s_ade_stall", tag), 32'(M_Stall), 32'd0);
         @(negedge clk);
         chk($sformatf("%s_ade_req", tag), 32'(data_req), 32'd0);
         chk($sformatf("%s_ade_wvalid", tag), 32'(W_Valid), 32'd0);
         dropM();
      end else begin
         chk($sformatf("%s_stall0", tag), 32'(M_Stall), 32'd1);
         @(negedge clk);
         chk($sformatf("%s_req", tag), 32'(data_req), 32'd1);
         chk($sformatf("%s_wr", tag), 32'(data_wr), 32'(tv.wr));
         chk($sformatf("%s_size", tag), 32'(data_size), 32'(tv.size));
         chk($sformatf("%s_addr", tag), data_addr, tv.bAddr);
         chk($sformatf("%s_wstrb", tag), 32'(data_wstrb), 32'(tv.wstrb));
         if (tv.wr) chk($sformatf("%s_wdata", tag), data_wdata, tv.wdata);
         data_addr_ok = 1'b1;
         @(negedge clk);
         data_addr_ok = 1'b0;
         #1;
         chk($sformatf("%s_req_wait", tag), 32'(data_req), 32'd0);
         chk($sformatf("%s_stall_wait", tag), 32'(M_Stall), 32'd1);
         data_data_ok = 1'b1; data_rdata = tv.rdata;
         #1;
         chk($sformatf("%s_stall_dok", tag), 32'(M_Stall), 32'd0);
         @(negedge clk);
         data_data_ok = 1'b0;
         dropM();
         if (!tv.wr) expRaw = tv.rdata;
         expOff = tv.addr[1:0];
         expExt = tv.ext;
         chkWb(tag, 1'b1);
         @(negedge clk);
         chk($sformatf("%s_wvalid_end", tag), 32'(W_Valid), 32'd0);
      end
   endtask

   initial begin
      //           acc      addr          sd            rdata         sz    bAddr         wstrb    wdata         wr    adel  ades  ext
      vecs[0]  = '{12'h010, 32'h00002002, 32'h000000A5, 32'h00000000, 2'd0, 32'h00002002, 4'b0100, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 9'h000};
      vecs[1]  = '{12'h002, 32'h00003001, 32'h11223344, 32'h00000000, 2'd2, 32'h00003000, 4'b0011, 32'h00001122, 1'b1, 1'b0, 1'b0, 9'h002};
      vecs[2]  = '{12'h001, 32'h00003001, 32'h11223344, 32'h00000000, 2'd2, 32'h00003000, 4'b1110, 32'h22334400, 1'b1, 1'b0, 1'b0, 9'h001};
      vecs[3]  = '{12'h008, 32'h00005002, 32'h0000BEEF, 32'h00000000, 2'd1, 32'h00005002, 4'b1100, 32'hBEEFBEEF, 1'b1, 1'b0, 1'b0, 9'h000};
      vecs[4]  = '{12'h004, 32'h00006000, 32'hCAFEF00D, 32'h00000000, 2'd2, 32'h00006000, 4'b1111, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 9'h000};
      vecs[5]  = '{12'h400, 32'h00007003, 32'h00000000, 32'h12345678, 2'd0, 32'h00007003, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 9'h080};
      vecs[6]  = '{12'h040, 32'h00008002, 32'h00000000, 32'hAABBCCDD, 2'd2, 32'h00008000, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 9'h008};
      vecs[7]  = '{12'h020, 32'h00008001, 32'h00000000, 32'h01020304, 2'd2, 32'h00008000, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 9'h004};
      vecs[8]  = '{12'h100, 32'h00009002, 32'h00000000, 32'h55667788, 2'd1, 32'h00009002, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 9'h020};
      vecs[9]  = '{12'h002, 32'h00003003, 32'h11223344, 32'h00000000, 2'd2, 32'h00003000, 4'b1111, 32'h11223344, 1'b1, 1'b0, 1'b0, 9'h002};
      vecs[10] = '{12'h200, 32'h00004001, 32'h00000000, 32'h00000000, 2'd1, 32'h00004001, 4'b0000, 32'h00000000, 1'b0, 1'b1, 1'b0, 9'h040};
      vecs[11] = '{12'h004, 32'h00006002, 32'h12345678, 32'h00000000, 2'd2, 32'h00006002, 4'b1111, 32'h12345678, 1'b1, 1'b0, 1'b1, 9'h000};
      vecs[12] = '{12'h008, 32'h00006001, 32'h00001234, 32'h00000000, 2'd1, 32'h00006001, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b1, 9'h000};
      vecs[13] = '{12'h800, 32'h0000A001, 32'h00000000, 32'h00000099, 2'd0, 32'h0000A001, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 9'h100};
      vecs[14] = '{12'h001, 32'h00003000, 32'h11223344, 32'h00000000, 2'd2, 32'h00003000, 4'b1111, 32'h11223344, 1'b1, 1'b0, 1'b0, 9'h001};
      vecs[15] = '{12'h080, 32'h00001003, 32'h00000000, 32'h00000000, 2'd2, 32'h00001003, 4'b0000, 32'h00000000, 1'b0, 1'b1, 1'b0, 9'h010};

      resetn = 1'b0;
      dropM();
      M_Addr = 32'h0; M_StoreData = 32'h0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      expRaw = 32'h0; expOff = 2'd0; expExt = 9'h0;

      // Reset state
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("rst_req", 32'(data_req), 32'd0);
      chk("rst_wr", 32'(data_wr), 32'd0);
      chk("rst_size", 32'(data_size), 32'd0);
      chk("rst_addr", data_addr, 32'h0);
      chk("rst_wstrb", 32'(data_wstrb), 32'd0);
      chk("rst_wdata", data_wdata, 32'h0);
      chk("rst_stall", 32'(M_Stall), 32'd0);
      chkWb("rst", 1'b0);

      // lw with addr_ok on the third REQ cycle and data_ok one cycle later
      @(negedge clk);
      present(12'h080, 32'h00001000, 32'h0);
      #1;
      chk("lwT_stall_start", 32'(M_Stall), 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("lwT_req_c%0d", c), 32'(data_req), 32'd1);
         chk($sformatf("lwT_size_c%0d", c), 32'(data_size), 32'd2);
         chk($sformatf("lwT_addr_c%0d", c), data_addr, 32'h00001000);
         chk($sformatf("lwT_stall_c%0d", c), 32'(M_Stall), 32'd1);
         if (c == 2) data_addr_ok = 1'b1;
      end
      @(negedge clk);
      data_addr_ok = 1'b0;
      #1;
      chk("lwT_req_wait", 32'(data_req), 32'd0);
      chk("lwT_stall_wait", 32'(M_Stall), 32'd1);
      data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
      #1;
      chk("lwT_stall_dok", 32'(M_Stall), 32'd0);
      @(negedge clk);
      data_data_ok = 1'b0;
      dropM();
      expRaw = 32'hDEADBEEF; expOff = 2'd0; expExt = 9'h010;
      chkWb("lwT", 1'b1);
      @(negedge clk);
      chk("lwT_wvalid_end", 32'(W_Valid), 32'd0);
      chk("lwT_req_end", 32'(data_req), 32'd0);

      // Table of single transactions
      for (int i = 0; i < 16; i++) runVec(vecs[i], $sformatf("v%0d", i));

      // Flush while waiting for data: result discarded, stall released at data_ok
      @(negedge clk);
      present(12'h080, 32'h0000B004, 32'h0);
      @(negedge clk);
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      M_Flush = 1'b1;
      #1;
      chk("fl_stall_flush", 32'(M_Stall), 32'd1);
      @(negedge clk);
      M_Flush = 1'b0;
      #1;
      chk("fl_stall_after", 32'(M_Stall), 32'd1);
      data_data_ok = 1'b1; data_rdata = 32'h0BADF00D;
      #1;
      chk("fl_stall_dok", 32'(M_Stall), 32'd0);
      @(negedge clk);
      data_data_ok = 1'b0;
      dropM();
      chkWb("fl", 1'b0);
      v = '{12'h800, 32'h0000C001, 32'h0, 32'h000000F0, 2'd0, 32'h0000C001, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 9'h100};
      runVec(v, "fl_lb");

      // Reset for one edge while in REQ abandons the transaction
      @(negedge clk);
      present(12'h080, 32'h0000D000, 32'h0);
      @(negedge clk);
      chk("rr_req_before", 32'(data_req), 32'd1);
      resetn = 1'b0;
      dropM();
      @(negedge clk);
      resetn = 1'b1;
      #1;
      expRaw = 32'h0; expOff = 2'd0; expExt = 9'h0;
      chk("rr_req", 32'(data_req), 32'd0);
      chk("rr_stall", 32'(M_Stall), 32'd0);
      chkWb("rr", 1'b0);
      v = '{12'h080, 32'h0000E004, 32'h0, 32'h13579BDF, 2'd2, 32'h0000E004, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 9'h010};
      runVec(v, "rr_lw");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage data-bus master. It sits directly upstream of the load-extension stage. It turns an M-stage load/store into one SRAM-like data-bus transaction (req/addr_ok/data_ok) and generates the store byte strobes and lane-shifted write data. It captures the returned raw word and hands it, with its byte offset and 9-bit extension type, to the extension stage. It stalls the pipeline while a transaction is outstanding and flags misaligned accesses.

Parameters:
ADDR_W, 32, data-bus address width
DATA_W, 32, data-bus data width (fixed 32; not otherwise supported)

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
M_Valid  in  1  M-stage instruction valid
M_Flush  in  1  exception/flush; current M instruction is cancelled
M_Addr  in  32  effective address
M_StoreData  in  32  rt value for stores
M_AccessType  in  12  one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,sb,sh,sw,swl,swr}; all-zero = no memory op
M_Stall  out  1  hold M and earlier stages
M_AdEL  out  1  load address error (combinational)
M_AdES  out  1  store address error (combinational)
data_req  out  1  bus request
data_wr  out  1  1 = write
data_size  out  2  0 byte, 1 half, 2 word
data_addr  out  32  bus address
data_wstrb  out  4  byte enables (writes)
data_wdata  out  32  write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data valid / write done
data_rdata  in  32  read data
W_Valid  out  1  one-cycle completion pulse
W_RawMemData  out  32  captured read word
W_Offset  out  2  M_Addr[1:0] of completed access
W_ExtType  out  9  {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr} of completed access

Behaviour:
- Reset (resetn low at a clk edge): state IDLE, cancel flag cleared. data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, W_* all 0. Reset mid-transaction abandons it; the memory side is reset together.
- start = IDLE & M_Valid & |M_AccessType & !M_Flush & !AdE.
- AdE: lh/lhu/sh with Addr[0]=1; lw/sw with Addr[1:0]!=0. Loads raise M_AdEL; stores raise M_AdES. lb/lbu/sb/lwl/lwr/swl/swr never fault. On AdE, no request is issued and there is no stall.
- FSM IDLE -> REQ on start. All bus fields plus offset/type are latched in the same edge.
- REQ: data_req=1; fields stay stable until addr_ok. REQ & addr_ok -> WAIT.
- WAIT: data_req=0. WAIT & data_ok -> IDLE. On that edge, W_RawMemData<=data_rdata (writes: unchanged), W_Offset, W_ExtType are loaded and W_Valid<=1 for one cycle, unless cancel is set.
- The bus never asserts data_ok in the same cycle as addr_ok for the same request. Minimum latency start->W_Valid is 3 edges.
- M_Stall = start | REQ | (WAIT & !data_ok). Stall drops in the data_ok cycle so the pipeline advances with the result.
- Flush in REQ or WAIT sets cancel. The transaction still completes on the bus, but the result is discarded: no W_Valid, W_* unchanged, and stall releases at data_ok. Flush in IDLE blocks start.
- Address/size:
  - lb/lbu/sb: size 0, full address.
  - lh/lhu/sh: size 1.
  - lw/sw: size 2.
  - lwl/lwr/swl/swr: size 2, address {Addr[31:2],2'b00}.
- Write strobes/data, with off = Addr[1:0]:
  - sb: wstrb 0001<<off; wdata byte replicated x4.
  - sh: wstrb 0011<<off; wdata half replicated x2.
  - sw: wstrb 1111; wdata as-is.
  - swl: wstrb 1111>>(3-off), i.e. off 0..3 -> 0001, 0011, 0111, 1111; wdata StoreData>>((3-off)*8).
  - swr: wstrb 1111<<off; wdata StoreData<<(off*8).
  - Loads: wstrb 0000, data_wr 0.
- W_ExtType takes bits {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr} of the latched type. Stores still pulse W_Valid with RawMemData unchanged.
- Upstream guarantee: a new M instruction is presented only after M_Stall was 0 at an edge.

Test Plan:
- lw Addr=0x1000, addr_ok after 2 cycles, data_ok 1 cycle later with rdata=0xDEADBEEF -> req held 3 cycles with size 2 and addr 0x1000; stall high until the data_ok cycle; W_Valid pulse with W_RawMemData=0xDEADBEEF, W_Offset=0, W_ExtType=lw.
- sb Addr=0x2002, StoreData=0x000000A5 -> data_wr=1, size 0, wstrb 0100, wdata 0xA5A5A5A5, W_Valid after data_ok.
- swl Addr=0x3001, StoreData=0x11223344 -> addr 0x3000, wstrb 0011, wdata 0x00001122; swr same address -> wstrb 1110, wdata 0x22334400.
- lh Addr=0x4001 -> M_AdEL=1, data_req never asserted, M_Stall=0, no W_Valid.
- lw issued, M_Flush asserted in WAIT, data_ok later -> no W_Valid, W_* unchanged, stall releases at data_ok; next lb proceeds normally.
- resetn low for one edge while in REQ -> next cycle data_req=0, state IDLE, all W_* zero; following lw completes with normal timing.
